// File: rtl/ex_mem_ccr_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_ccr_stage_pkg
//  Description : Shared constants and types for the EX/MEM stage and its
//                condition-code unit: datapath widths, CCR bit positions,
//                conditional-jump encodings and the flag-save FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_ccr_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int CCR_W  = 3;

    // CCR bit positions
    localparam int C_BIT = 2;
    localparam int N_BIT = 1;
    localparam int Z_BIT = 0;

    // Conditional jump encodings
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_Z    = 2'b01;
    localparam logic [1:0] JMP_N    = 2'b10;
    localparam logic [1:0] JMP_C    = 2'b11;

    // Single-level flag save slot
    typedef enum logic [0:0] {
        SAVE_EMPTY = 1'b0,
        SAVE_HELD  = 1'b1
    } save_state_e;

endpackage : ex_mem_ccr_stage_pkg
`default_nettype wire

// File: rtl/ex_mem_ccr_stage_ccr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ccr_unit
//  Description : Architectural condition-code register. Applies the flag
//                update priority (restore > ALU write > setc/clrc > jump
//                clear), evaluates conditional jumps against the current
//                flags and keeps a single-level interrupt save slot.
//  Ports       : i_ex_valid/i_flush/i_stall qualify the EX instruction;
//                i_ccr_we/i_alu_ccr, i_setc/i_clrc, i_jmp_type,
//                i_int_save/i_rti_restore request flag changes;
//                o_ccr_q current flags, o_jmp_taken jump decision,
//                o_saved_valid save slot occupied.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccr_unit
    import ex_mem_ccr_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ex_valid,
    input  logic             i_flush,
    input  logic             i_stall,
    input  logic             i_ccr_we,
    input  logic [CCR_W-1:0] i_alu_ccr,
    input  logic             i_setc,
    input  logic             i_clrc,
    input  logic [1:0]       i_jmp_type,
    input  logic             i_int_save,
    input  logic             i_rti_restore,
    output logic [CCR_W-1:0] o_ccr_q,
    output logic             o_jmp_taken,
    output logic             o_saved_valid
);

    save_state_e      r_state;
    save_state_e      w_state_nxt;
    logic [CCR_W-1:0] r_ccr;
    logic [CCR_W-1:0] w_ccr_nxt;
    logic [CCR_W-1:0] r_saved;
    logic [CCR_W-1:0] w_saved_nxt;
    logic             w_eff;
    logic             w_jmp_hit;
    logic             w_restore;

    assign w_eff     = i_ex_valid & ~i_flush & ~i_stall;
    assign w_restore = i_rti_restore & (r_state == SAVE_HELD);

    // Condition test against the registered flags only
    always_comb begin
        w_jmp_hit = 1'b0;
        case (i_jmp_type)
            JMP_NONE: w_jmp_hit = 1'b0;
            JMP_Z:    w_jmp_hit = r_ccr[Z_BIT];
            JMP_N:    w_jmp_hit = r_ccr[N_BIT];
            JMP_C:    w_jmp_hit = r_ccr[C_BIT];
            default:  w_jmp_hit = 1'b0;
        endcase
    end

    assign o_jmp_taken = w_eff & w_jmp_hit;

    // Flag next-state. alu_ccr is only looked at on the ccr_we branch because
    // a disabled ALU unit leaves it floating.
    always_comb begin
        w_ccr_nxt = r_ccr;
        if (w_eff) begin
            if (w_restore) begin
                w_ccr_nxt = r_saved;
            end else if (i_ccr_we) begin
                w_ccr_nxt = i_alu_ccr;
            end else if (i_setc | i_clrc) begin
                w_ccr_nxt[C_BIT] = i_setc;
            end else if (w_jmp_hit) begin
                case (i_jmp_type)
                    JMP_Z:   w_ccr_nxt[Z_BIT] = 1'b0;
                    JMP_N:   w_ccr_nxt[N_BIT] = 1'b0;
                    JMP_C:   w_ccr_nxt[C_BIT] = 1'b0;
                    default: w_ccr_nxt = r_ccr;
                endcase
            end
        end
    end

    // Save slot FSM. The saved value is the flags before this cycle's update.
    // A save in HELD overwrites the slot and wins over a simultaneous restore
    // for the FSM state; the restore still reads the old slot value above.
    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        if (w_eff) begin
            case (r_state)
                SAVE_EMPTY: begin
                    if (i_int_save) begin
                        w_state_nxt = SAVE_HELD;
                        w_saved_nxt = r_ccr;
                    end
                end
                SAVE_HELD: begin
                    if (i_int_save) begin
                        w_saved_nxt = r_ccr;
                    end else if (i_rti_restore) begin
                        w_state_nxt = SAVE_EMPTY;
                    end
                end
                default: w_state_nxt = SAVE_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SAVE_EMPTY;
            r_ccr   <= '0;
            r_saved <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ccr   <= w_ccr_nxt;
            r_saved <= w_saved_nxt;
        end
    end

    assign o_ccr_q       = r_ccr;
    assign o_saved_valid = (r_state == SAVE_HELD);

endmodule : ccr_unit
`default_nettype wire

// File: rtl/ex_mem_ccr_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_ccr_stage
//  Description : EX/MEM pipeline latch plus the condition-code unit. Latches
//                the selected ALU result and downstream controls with one
//                cycle of latency (hold on stall, bubble on flush), and
//                exposes the CCR as previous flags for the ALU.
//  Ports       : alu_out/alu_ccr ALU result and flags; ex_* EX controls;
//                stall/flush pipeline control; ccr_q flags; jmp_taken jump
//                decision; mem_* latched stage outputs; saved_valid save
//                slot occupied.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_ccr_stage
    import ex_mem_ccr_stage_pkg::*;
#(
    parameter int DATA_W = ex_mem_ccr_stage_pkg::DATA_W,
    parameter int REG_AW = ex_mem_ccr_stage_pkg::REG_AW,
    parameter int CCR_W  = ex_mem_ccr_stage_pkg::CCR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [CCR_W-1:0]  alu_ccr,
    input  logic              ex_valid,
    input  logic              ccr_we,
    input  logic              setc,
    input  logic              clrc,
    input  logic [1:0]        jmp_type,
    input  logic              int_save,
    input  logic              rti_restore,
    input  logic [REG_AW-1:0] ex_rdst,
    input  logic              ex_wb_en,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic              stall,
    input  logic              flush,
    output logic [CCR_W-1:0]  ccr_q,
    output logic              jmp_taken,
    output logic [DATA_W-1:0] mem_result,
    output logic [REG_AW-1:0] mem_rdst,
    output logic              mem_wb_en,
    output logic              mem_mem_rd,
    output logic              mem_mem_wr,
    output logic              mem_valid,
    output logic              saved_valid
);

    logic [DATA_W-1:0] r_result;
    logic [REG_AW-1:0] r_rdst;
    logic              r_wb_en;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_valid;

    ccr_unit u_ccr_unit (
        .clk           (clk),
        .rst           (rst),
        .i_ex_valid    (ex_valid),
        .i_flush       (flush),
        .i_stall       (stall),
        .i_ccr_we      (ccr_we),
        .i_alu_ccr     (alu_ccr),
        .i_setc        (setc),
        .i_clrc        (clrc),
        .i_jmp_type    (jmp_type),
        .i_int_save    (int_save),
        .i_rti_restore (rti_restore),
        .o_ccr_q       (ccr_q),
        .o_jmp_taken   (jmp_taken),
        .o_saved_valid (saved_valid)
    );

    // Stall holds everything; flush inserts an all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_rdst   <= '0;
            r_wb_en  <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_valid  <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                r_result <= '0;
                r_rdst   <= '0;
                r_wb_en  <= 1'b0;
                r_mem_rd <= 1'b0;
                r_mem_wr <= 1'b0;
                r_valid  <= 1'b0;
            end else begin
                r_result <= alu_out;
                r_rdst   <= ex_rdst;
                r_wb_en  <= ex_wb_en;
                r_mem_rd <= ex_mem_rd;
                r_mem_wr <= ex_mem_wr;
                r_valid  <= ex_valid;
            end
        end
    end

    assign mem_result = r_result;
    assign mem_rdst   = r_rdst;
    assign mem_wb_en  = r_wb_en;
    assign mem_mem_rd = r_mem_rd;
    assign mem_mem_wr = r_mem_wr;
    assign mem_valid  = r_valid;

endmodule : ex_mem_ccr_stage
`default_nettype wire

// File: tb/tb_ex_mem_ccr_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_ccr_stage
//  Description : Directed self-checking bench for ex_mem_ccr_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_ccr_stage;

    localparam int C_DATA_W = 16;
    localparam int C_REG_AW = 3;
    localparam int C_CCR_W  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [C_DATA_W-1:0] alu_out;
    logic [C_CCR_W-1:0]  alu_ccr;
    logic                ex_valid, ccr_we, setc, clrc;
    logic [1:0]          jmp_type;
    logic                int_save, rti_restore;
    logic [C_REG_AW-1:0] ex_rdst;
    logic                ex_wb_en, ex_mem_rd, ex_mem_wr, stall, flush;
    logic [C_CCR_W-1:0]  ccr_q;
    logic                jmp_taken;
    logic [C_DATA_W-1:0] mem_result;
    logic [C_REG_AW-1:0] mem_rdst;
    logic                mem_wb_en, mem_mem_rd, mem_mem_wr, mem_valid;
    logic                saved_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_mem_ccr_stage dut (
        .clk         (clk),
        .rst         (rst),
        .alu_out     (alu_out),
        .alu_ccr     (alu_ccr),
        .ex_valid    (ex_valid),
        .ccr_we      (ccr_we),
        .setc        (setc),
        .clrc        (clrc),
        .jmp_type    (jmp_type),
        .int_save    (int_save),
        .rti_restore (rti_restore),
        .ex_rdst     (ex_rdst),
        .ex_wb_en    (ex_wb_en),
        .ex_mem_rd   (ex_mem_rd),
        .ex_mem_wr   (ex_mem_wr),
        .stall       (stall),
        .flush       (flush),
        .ccr_q       (ccr_q),
        .jmp_taken   (jmp_taken),
        .mem_result  (mem_result),
        .mem_rdst    (mem_rdst),
        .mem_wb_en   (mem_wb_en),
        .mem_mem_rd  (mem_mem_rd),
        .mem_mem_wr  (mem_mem_wr),
        .mem_valid   (mem_valid),
        .saved_valid (saved_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_out = '0; alu_ccr = '0; ex_valid = 0; ccr_we = 0; setc = 0; clrc = 0;
        jmp_type = 2'b00; int_save = 0; rti_restore = 0; ex_rdst = '0;
        ex_wb_en = 0; ex_mem_rd = 0; ex_mem_wr = 0; stall = 0; flush = 0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        check("reset_ccr",     32'(ccr_q), 32'h0);
        check("reset_valid",   32'(mem_valid), 32'h0);
        check("reset_saved",   32'(saved_valid), 32'h0);
        check("reset_result",  32'(mem_result), 32'h0);

        // Flag update with a zero result
        ex_valid = 1; ccr_we = 1; alu_out = 16'h0000; alu_ccr = 3'b101;
        ex_wb_en = 1; ex_rdst = 3'd3;
        step();
        check("upd_ccr",    32'(ccr_q), 32'h5);
        check("upd_result", 32'(mem_result), 32'h0);
        check("upd_valid",  32'(mem_valid), 32'h1);
        check("upd_wb",     32'(mem_wb_en), 32'h1);
        check("upd_rdst",   32'(mem_rdst), 32'h3);

        // JZ taken clears Z
        alu_ccr = 3'b001;
        step();
        check("jz_setup", 32'(ccr_q), 32'h1);
        ccr_we = 0; jmp_type = 2'b01;
        #1;
        check("jz_taken", 32'(jmp_taken), 32'h1);
        step();
        check("jz_clear", 32'(ccr_q), 32'h0);
        jmp_type = 2'b10;
        #1;
        check("jn_not_taken", 32'(jmp_taken), 32'h0);

        // Prime the latch, then stall
        jmp_type = 2'b00; ccr_we = 1; alu_ccr = 3'b010; alu_out = 16'hABCD; ex_rdst = 3'd5;
        step();
        check("pre_stall_ccr", 32'(ccr_q), 32'h2);
        check("pre_stall_res", 32'(mem_result), 32'hABCD);
        stall = 1; alu_out = 16'h1234; alu_ccr = 3'b111; jmp_type = 2'b10;
        #1;
        check("stall_no_jump", 32'(jmp_taken), 32'h0);
        step();
        check("stall_result", 32'(mem_result), 32'hABCD);
        check("stall_rdst",   32'(mem_rdst), 32'h5);
        check("stall_valid",  32'(mem_valid), 32'h1);
        check("stall_ccr",    32'(ccr_q), 32'h2);

        // Flush bubbles the latch and blocks the flag write
        stall = 0; flush = 1; jmp_type = 2'b00;
        step();
        check("flush_valid",  32'(mem_valid), 32'h0);
        check("flush_wb",     32'(mem_wb_en), 32'h0);
        check("flush_result", 32'(mem_result), 32'h0);
        check("flush_ccr",    32'(ccr_q), 32'h2);

        // Interrupt save/restore
        flush = 0; alu_ccr = 3'b110;
        step();
        check("int_setup", 32'(ccr_q), 32'h6);
        ccr_we = 0; int_save = 1;
        step();
        check("int_saved",  32'(saved_valid), 32'h1);
        check("int_ccr",    32'(ccr_q), 32'h6);
        int_save = 0; ccr_we = 1; alu_ccr = 3'b001;
        step();
        check("int_body_ccr", 32'(ccr_q), 32'h1);
        ccr_we = 0; rti_restore = 1;
        step();
        check("rti_ccr",   32'(ccr_q), 32'h6);
        check("rti_saved", 32'(saved_valid), 32'h0);
        // Restore with nothing held falls through to the ALU write
        ccr_we = 1; alu_ccr = 3'b011;
        step();
        check("rti_empty_ccr",   32'(ccr_q), 32'h3);
        check("rti_empty_saved", 32'(saved_valid), 32'h0);

        // Save and restore together while HELD
        rti_restore = 0; ccr_we = 0; int_save = 1;
        step();
        check("nest_saved", 32'(saved_valid), 32'h1);
        int_save = 0; ccr_we = 1; alu_ccr = 3'b100;
        step();
        check("nest_body", 32'(ccr_q), 32'h4);
        ccr_we = 0; int_save = 1; rti_restore = 1;
        step();
        check("swap_ccr",   32'(ccr_q), 32'h3);
        check("swap_saved", 32'(saved_valid), 32'h1);
        int_save = 0;
        step();
        check("swap_rti_ccr",   32'(ccr_q), 32'h4);
        check("swap_rti_saved", 32'(saved_valid), 32'h0);

        // setc/clrc priority
        rti_restore = 0; ccr_we = 1; alu_ccr = 3'b010;
        step();
        ccr_we = 0; setc = 1; clrc = 1;
        step();
        check("setc_wins", 32'(ccr_q), 32'h6);
        setc = 0;
        step();
        check("clrc_only", 32'(ccr_q), 32'h2);
        clrc = 0; setc = 1; ccr_we = 1; alu_ccr = 3'b001;
        step();
        check("we_over_setc", 32'(ccr_q), 32'h1);

        // JC taken clears C only
        ccr_we = 0;
        step();
        check("jc_setup", 32'(ccr_q), 32'h5);
        setc = 0; jmp_type = 2'b11;
        #1;
        check("jc_taken", 32'(jmp_taken), 32'h1);
        step();
        check("jc_clear", 32'(ccr_q), 32'h1);

        // Hold a save, then reset asynchronously mid-cycle
        jmp_type = 2'b00; int_save = 1;
        step();
        int_save = 0; ex_valid = 0;
        check("pre_rst_saved", 32'(saved_valid), 32'h1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ccr",   32'(ccr_q), 32'h0);
        check("async_rst_valid", 32'(mem_valid), 32'h0);
        check("async_rst_saved", 32'(saved_valid), 32'h0);
        #2;
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ex_mem_ccr_stage
`default_nettype wire
